edge_event_detector: RTL and testbench

EDGE_EVENT_DETECTOR -- requirements
Module: edge_event_detector

---
 rtl/edge_det_pkg.sv | 36 +++
 rtl/edge_det_channel.sv | 138 +++++++++++++
 rtl/edge_event_detector.sv | 64 ++++++
 tb/tb_edge_event_detector.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_det_pkg
//  Description : Shared definitions for the edge/event detector. Holds the
//                per-channel edge-select encodings, the supported parameter
//                ranges, and small decode helpers for the mode field.
//  Revision    : 1.0 - initial release
// ============================================================================
package edge_det_pkg;

    // Per-channel edge selection, two bits per channel.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Supported parameter ranges.
    localparam int unsigned NUM_CH_MIN      = 1;
    localparam int unsigned NUM_CH_MAX      = 32;
    localparam int unsigned SYNC_STAGES_MIN = 1;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // True when the mode field enables rising-edge pulses.
    function automatic logic mode_has_rise(input logic [1:0] m);
        return (mode_e'(m) == MODE_RISE) || (mode_e'(m) == MODE_BOTH);
    endfunction

    // True when the mode field enables falling-edge pulses.
    function automatic logic mode_has_fall(input logic [1:0] m);
        return (mode_e'(m) == MODE_FALL) || (mode_e'(m) == MODE_BOTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_det_channel.sv
`default_nettype none
// ============================================================================
//  Module      : edge_det_channel
//  Description : One detector channel: synchroniser chain, glitch filter,
//                one-cycle edge pulse generation and sticky event flag.
//  Ports       : clk       - clock, all state on rising edge
//                rst_n     - synchronous active-low reset
//                sig_in    - asynchronous channel input
//                mode      - edge select (off / rise / fall / both)
//                filt_len  - glitch-filter length, 0 = no filtering
//                ev_clear  - level-sensitive sticky-flag clear
//                sig_filt  - filtered, synchronised level
//                pulse_out - one-cycle pulse per accepted edge
//                ev_flag   - sticky event flag
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic [1:0]        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              ev_clear,
    output logic              sig_filt,
    output logic              pulse_out,
    output logic              ev_flag
);

    // ------------------------------------------------------------------
    // Synchroniser chain; stage SYNC_STAGES-1 is the synchronised level.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_out;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            assign sync_d = sig_in;
        end else begin : g_sync_chain
            assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    endgenerate

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter. The counter measures how long the synchronised level
    // has disagreed with the filtered level. Using >= rather than == means
    // a count already past a freshly reduced filt_len still commits on the
    // next compare instead of wrapping round.
    // ------------------------------------------------------------------
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic              sig_filt_q;
    logic              sig_filt_d;
    logic              filt_dly_q;

    always_comb begin
        cnt_d      = cnt_q;
        sig_filt_d = sig_filt_q;
        if (sync_out == sig_filt_q) begin
            cnt_d = '0;
        end else if (cnt_q < filt_len) begin
            cnt_d = cnt_q + FILT_W'(1);
        end else begin
            sig_filt_d = sync_out;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sig_filt_q <= IDLE_LEVEL;
            filt_dly_q <= IDLE_LEVEL;
        end else begin
            cnt_q      <= cnt_d;
            sig_filt_q <= sig_filt_d;
            filt_dly_q <= sig_filt_q;
        end
    end

    // ------------------------------------------------------------------
    // Edge gate: purely from registers, so no path from sig_in. Reset
    // loads the filtered level and its delayed copy with the same value,
    // so no edge is seen coming out of reset.
    // ------------------------------------------------------------------
    logic rise;
    logic fall;
    logic pulse;

    assign rise  = sig_filt_q & ~filt_dly_q;
    assign fall  = ~sig_filt_q & filt_dly_q;
    assign pulse = (rise & mode_has_rise(mode)) | (fall & mode_has_fall(mode));

    // ------------------------------------------------------------------
    // Sticky flag: a pulse in the current cycle beats a clear.
    // ------------------------------------------------------------------
    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (pulse) begin
            flag_d = 1'b1;
        end else if (ev_clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign sig_filt  = sig_filt_q;
    assign pulse_out = pulse;
    assign ev_flag   = flag_q;

endmodule
`default_nettype wire

// File: rtl/edge_event_detector.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_detector
//  Description : Multi-channel edge/event detector. Each channel is an
//                edge_det_channel instance; the interrupt is the OR of the
//                enabled sticky flags.
//  Ports       : clk, rst_n (sync, active-low)
//                sig_in[NUM_CH]       - asynchronous inputs
//                mode[2*NUM_CH]       - per-channel edge select
//                filt_len[FILT_W]     - shared glitch-filter length
//                irq_en[NUM_CH]       - per-channel interrupt enable
//                ev_clear[NUM_CH]     - per-channel sticky clear
//                sig_filt[NUM_CH]     - filtered levels
//                pulse_out[NUM_CH]    - one-cycle edge pulses
//                ev_flag[NUM_CH]      - sticky event flags
//                irq                  - combined interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_detector
    import edge_det_pkg::*;
#(
    parameter int unsigned        NUM_CH      = 4,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter int unsigned        FILT_W      = 4,
    parameter logic [NUM_CH-1:0]  IDLE_LEVEL  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     sig_in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic [NUM_CH-1:0]     irq_en,
    input  logic [NUM_CH-1:0]     ev_clear,
    output logic [NUM_CH-1:0]     sig_filt,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     ev_flag,
    output logic                  irq
);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            edge_det_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_W      (FILT_W),
                .IDLE_LEVEL  (IDLE_LEVEL[i])
            ) u_channel (
                .clk       (clk),
                .rst_n     (rst_n),
                .sig_in    (sig_in[i]),
                .mode      (mode[2*i +: 2]),
                .filt_len  (filt_len),
                .ev_clear  (ev_clear[i]),
                .sig_filt  (sig_filt[i]),
                .pulse_out (pulse_out[i]),
                .ev_flag   (ev_flag[i])
            );
        end
    endgenerate

    // Combinational so that irq_en changes are visible in the same cycle.
    assign irq = |(ev_flag & irq_en);

endmodule
`default_nettype wire

// File: tb/tb_edge_event_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_detector
//  Description : Self-checking bench for edge_event_detector: a directed
//                vector table, hand-written corner sequences, and random
//                stimulus checked against a behavioural history-window model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_detector;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int FW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (idle level all zero)
    logic             rst_n;
    logic [NCH-1:0]   sig_in;
    logic [2*NCH-1:0] mode;
    logic [FW-1:0]    filt_len;
    logic [NCH-1:0]   irq_en;
    logic [NCH-1:0]   ev_clear;
    logic [NCH-1:0]   sig_filt;
    logic [NCH-1:0]   pulse_out;
    logic [NCH-1:0]   ev_flag;
    logic             irq;

    // Second DUT with a non-zero idle level
    logic             rst1_n;
    logic [NCH-1:0]   sig_in1;
    logic [2*NCH-1:0] mode1;
    logic [FW-1:0]    filt_len1;
    logic [NCH-1:0]   irq_en1;
    logic [NCH-1:0]   ev_clear1;
    logic [NCH-1:0]   sig_filt1;
    logic [NCH-1:0]   pulse_out1;
    logic [NCH-1:0]   ev_flag1;
    logic             irq1;

    edge_event_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .FILT_W(FW), .IDLE_LEVEL(4'b0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .mode(mode),
        .filt_len(filt_len), .irq_en(irq_en), .ev_clear(ev_clear),
        .sig_filt(sig_filt), .pulse_out(pulse_out), .ev_flag(ev_flag),
        .irq(irq)
    );

    edge_event_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .FILT_W(FW), .IDLE_LEVEL(4'b0001)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .sig_in(sig_in1), .mode(mode1),
        .filt_len(filt_len1), .irq_en(irq_en1), .ev_clear(ev_clear1),
        .sig_filt(sig_filt1), .pulse_out(pulse_out1), .ev_flag(ev_flag1),
        .irq(irq1)
    );

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Reference model. Keeps the raw input history and the history of the
    // synchronised level; a channel's filtered level flips when the most
    // recent filt_len+1 synchronised samples all disagree with it.
    // ------------------------------------------------------------------
    logic [NCH-1:0] m_filt;
    logic [NCH-1:0] m_flag;
    logic [1:0]     m_evt [NCH];   // 0 none, 1 rose last edge, 2 fell last edge
    logic [63:0]    in_hist [NCH]; // bit 0 = newest sample of sig_in
    logic [63:0]    so_hist [NCH]; // bit 0 = newest synchronised sample
    int             m_n;           // edges since reset released

    function automatic logic [NCH-1:0] model_pulse(input logic [2*NCH-1:0] md);
        logic [NCH-1:0] p;
        p = '0;
        for (int c = 0; c < NCH; c++)
            p[c] = ((m_evt[c] == 2'd1) && md[2*c]) || ((m_evt[c] == 2'd2) && md[2*c+1]);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // One clock cycle: sample inputs, advance model at posedge, compare at negedge.
    task automatic tick();
        logic [NCH-1:0]   c_sig, c_clr, pre;
        logic             c_rst;
        int               c_len;
        logic             so, flip;
        c_sig = sig_in;
        c_clr = ev_clear;
        c_rst = rst_n;
        c_len = int'(filt_len);
        pre   = model_pulse(mode);
        @(posedge clk);
        if (!c_rst) begin
            m_filt = '0;
            m_flag = '0;
            m_n    = 0;
            for (int c = 0; c < NCH; c++) begin
                m_evt[c]   = 2'd0;
                in_hist[c] = '0;
                so_hist[c] = '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                so = (m_n >= SS) ? in_hist[c][SS-1] : 1'b0;
                so_hist[c] = {so_hist[c][62:0], so};
                flip = 1'b1;
                for (int j = 0; j <= c_len; j++)
                    if (j > m_n || so_hist[c][j] == m_filt[c]) flip = 1'b0;
                if (flip) begin
                    m_filt[c] = ~m_filt[c];
                    m_evt[c]  = m_filt[c] ? 2'd1 : 2'd2;
                end else begin
                    m_evt[c]  = 2'd0;
                end
                if (pre[c])        m_flag[c] = 1'b1;
                else if (c_clr[c]) m_flag[c] = 1'b0;
                in_hist[c] = {in_hist[c][62:0], c_sig[c]};
            end
            if (m_n < 60) m_n++;
        end
        @(negedge clk);
        chk("model_sig_filt", 32'(sig_filt), 32'(m_filt));
        chk("model_pulse_out", 32'(pulse_out), 32'(model_pulse(mode)));
        chk("model_ev_flag", 32'(ev_flag), 32'(m_flag));
        chk("model_irq", 32'(irq), 32'(|(m_flag & irq_en)));
    endtask

    // Run n cycles, counting rise/fall pulses and filtered-level toggles on one channel.
    task automatic run(input int n, input int ch, output int rc, output int fc, output int tg);
        logic prev;
        prev = sig_filt[ch];
        rc = 0; fc = 0; tg = 0;
        repeat (n) begin
            tick();
            if (pulse_out[ch]) begin
                if (sig_filt[ch]) rc++;
                else              fc++;
            end
            if (sig_filt[ch] != prev) tg++;
            prev = sig_filt[ch];
        end
    endtask

    typedef struct {
        logic           rst;
        logic [NCH-1:0] sig;
        logic [NCH-1:0] ien;
        logic [NCH-1:0] clr;
        logic [NCH-1:0] e_filt;
        logic [NCH-1:0] e_pulse;
        logic [NCH-1:0] e_flag;
        logic           e_irq;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int rc, fc, tg, waited;
        bit found;

        rst_n = 1'b0; sig_in = '0; mode = '0; filt_len = '0;
        irq_en = '0; ev_clear = '0;
        rst1_n = 1'b0; sig_in1 = 4'b0001; mode1 = 8'hFF; filt_len1 = '0;
        irq_en1 = 4'hF; ev_clear1 = '0;
        m_filt = '0; m_flag = '0; m_n = 0;
        for (int c = 0; c < NCH; c++) begin
            m_evt[c] = 2'd0; in_hist[c] = '0; so_hist[c] = '0;
        end

        tick();
        tick();
        chk("reset_pulse", 32'(pulse_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // ---------------- Directed table: ch0 rise, filt_len=0 -----------
        //            rst  sig    ien    clr    filt   pulse  flag   irq
        tbl[0] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2] = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[3] = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0};
        tbl[4] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 1'b1};
        tbl[5] = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[6] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[7] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
        tbl[8] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        mode = 8'h01;
        for (int k = 0; k < 9; k++) begin
            rst_n = tbl[k].rst; sig_in = tbl[k].sig;
            irq_en = tbl[k].ien; ev_clear = tbl[k].clr;
            tick();
            chk($sformatf("tbl%0d_sig_filt", k), 32'(sig_filt), 32'(tbl[k].e_filt));
            chk($sformatf("tbl%0d_pulse", k), 32'(pulse_out), 32'(tbl[k].e_pulse));
            chk($sformatf("tbl%0d_flag", k), 32'(ev_flag), 32'(tbl[k].e_flag));
            chk($sformatf("tbl%0d_irq", k), 32'(irq), 32'(tbl[k].e_irq));
        end
        irq_en = '0;

        // ---------------- ch1 glitch filter, filt_len=3, both edges -------
        filt_len = 4'd3; mode = 8'b0000_1100;
        run(6, 1, rc, fc, tg);
        sig_in[1] = 1'b1;
        run(3, 1, rc, fc, tg);
        sig_in[1] = 1'b0;
        begin
            int r2, f2, t2;
            run(12, 1, r2, f2, t2);
            chk("glitch3_pulses", 32'(rc + fc + r2 + f2), 32'd0);
        end
        chk("glitch3_flag", 32'(ev_flag[1]), 32'd0);
        sig_in[1] = 1'b1;
        run(4, 1, rc, fc, tg);
        sig_in[1] = 1'b0;
        begin
            int r2, f2, t2;
            run(14, 1, r2, f2, t2);
            chk("hold4_rise", 32'(rc + r2), 32'd1);
            chk("hold4_fall", 32'(fc + f2), 32'd1);
        end
        chk("hold4_flag", 32'(ev_flag[1]), 32'd1);

        // ---------------- ch2 fall-only, then mode off -------------------
        filt_len = 4'd0; mode = 8'b0010_0000; ev_clear = 4'hF;
        tick();
        ev_clear = '0;
        sig_in[2] = 1'b1;
        run(10, 2, rc, fc, tg);
        chk("fallonly_rise_cnt", 32'(rc), 32'd0);
        sig_in[2] = 1'b0;
        run(10, 2, rc, fc, tg);
        chk("fallonly_fall_cnt", 32'(fc), 32'd1);
        mode = 8'h00;
        sig_in[2] = 1'b1;
        run(10, 2, rc, fc, tg);
        chk("modeoff_rise_pulses", 32'(rc + fc), 32'd0);
        chk("modeoff_track_hi", 32'(tg), 32'd1);
        sig_in[2] = 1'b0;
        run(10, 2, rc, fc, tg);
        chk("modeoff_fall_pulses", 32'(rc + fc), 32'd0);
        chk("modeoff_track_lo", 32'(tg), 32'd1);

        // ---------------- ch3 sticky flag and irq ------------------------
        mode = 8'b0100_0000; irq_en = 4'b1000; ev_clear = 4'hF;
        tick();
        ev_clear = '0;
        sig_in[3] = 1'b1;
        run(6, 3, rc, fc, tg);
        chk("ch3_flag_set", 32'(ev_flag[3]), 32'd1);
        chk("ch3_irq", 32'(irq), 32'd1);
        sig_in[3] = 1'b0;
        run(6, 3, rc, fc, tg);
        sig_in[3] = 1'b1;
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            tick();
            if (pulse_out[3]) found = 1'b1;
        end
        chk("ch3_pulse_seen", 32'(found), 32'd1);
        ev_clear[3] = 1'b1;
        tick();
        chk("ch3_set_wins", 32'(ev_flag[3]), 32'd1);
        tick();
        chk("ch3_clear_alone", 32'(ev_flag[3]), 32'd0);
        ev_clear[3] = 1'b0;
        sig_in[3] = 1'b0;
        run(4, 3, rc, fc, tg);
        sig_in[3] = 1'b1;
        run(5, 3, rc, fc, tg);
        irq_en = 4'b0000;
        #1;
        chk("irq_en_off_same_cycle", 32'(irq), 32'd0);
        irq_en = 4'b1000;
        #1;
        chk("irq_en_on_same_cycle", 32'(irq), 32'd1);
        irq_en = '0;

        // ---------------- non-zero idle level through reset --------------
        chk("idle1_filt_in_reset", 32'(sig_filt1), 32'h1);
        chk("idle1_pulse_in_reset", 32'(pulse_out1), 32'h0);
        rst1_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("idle1_pulse", 32'(pulse_out1), 32'h0);
            chk("idle1_flag", 32'(ev_flag1), 32'h0);
            chk("idle1_filt", 32'(sig_filt1), 32'h1);
        end
        chk("idle1_irq", 32'(irq1), 32'h0);

        // ---------------- reset mid-count, filt_len=15 -------------------
        ev_clear = 4'hF; sig_in = '0; mode = 8'h01; filt_len = 4'd15;
        tick();
        ev_clear = '0;
        run(20, 0, rc, fc, tg);
        sig_in[0] = 1'b1;
        run(10, 0, rc, fc, tg);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_filt", 32'(sig_filt[0]), 32'd0);
        chk("midreset_flag", 32'(ev_flag[0]), 32'd0);
        waited = 0;
        found  = 1'b0;
        for (int w = 1; w <= 40 && !found; w++) begin
            tick();
            if (sig_filt[0]) begin
                found  = 1'b1;
                waited = w;
            end
        end
        chk("midreset_relatency", 32'(waited), 32'd18);

        // ---------------- randomized segments vs model -------------------
        for (int seg = 0; seg < 4; seg++) begin
            rst_n = 1'b0; sig_in = 4'($urandom);
            tick();
            rst_n = 1'b1;
            filt_len = 4'($urandom_range(0, 4));
            mode     = 8'($urandom);
            irq_en   = 4'($urandom);
            for (int cyc = 0; cyc < 250; cyc++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 3) == 0) sig_in[c] = ~sig_in[c];
                    ev_clear[c] = ($urandom_range(0, 7) == 0);
                end
                if ($urandom_range(0, 49) == 0) filt_len = 4'($urandom_range(0, 6));
                if ($urandom_range(0, 39) == 0) mode     = 8'($urandom);
                if ($urandom_range(0, 29) == 0) irq_en   = 4'($urandom);
                if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
                else                             rst_n = 1'b1;
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
